// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: RAW/multi-cycle/redirect stall and squash control; define PIPELINE_HAZARD_FWD_EN for operand forwarding.
module pipeline_hazard_unit #(
  parameter int AW = 5,
  parameter int FLAGS_W = 17,
  parameter int WB_STAGES = 2,
  parameter int WE_BIT = 0,
  parameter int LOAD_BIT = 4,
  parameter int JALR_BIT = 9,
  parameter int BRANCH_BIT = 11,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 16,
  parameter int STALL_TIMEOUT = 255,
  localparam int SW = $clog2(WB_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AW-1:0]                dec_rs1,
  input  logic [AW-1:0]                dec_rs2,
  input  logic [FLAGS_W-1:0]           ra_flags,
  input  logic [AW-1:0]                ra_rs1,
  input  logic [AW-1:0]                ra_rs2,
  input  logic [AW-1:0]                ra_rd,
  input  logic [WB_STAGES*FLAGS_W-1:0] wb_flags,
  input  logic [WB_STAGES*AW-1:0]      wb_rd,
  input  logic                         redirect,
  input  logic                         alu_busy,
  output logic                         fetch_en,
  output logic                         dec_latch_en,
  output logic                         ra_latch_en,
  output logic                         alu_latch_en,
  output logic                         dec_squash,
  output logic                         ra_squash,
  output logic                         jmpctrl_en,
  output logic [SW-1:0]                fwd_rs1_sel,
  output logic [SW-1:0]                fwd_rs2_sel,
  output logic [CNT_W-1:0]             stall_count,
  output logic                         stall_timeout
);
  localparam int FCW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW = $clog2(STALL_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, STALL_DATA, STALL_MC, FLUSH} state_t;
  state_t state;
  logic [FCW-1:0] flush_cnt;
  logic [TW-1:0] run_len;
  logic hz_dec, hz_ra, ld1, ld2, haz_dec, haz_ra, flush;
  logic [SW-1:0] sel1, sel2;
  function automatic logic hit(input logic [FLAGS_W-1:0] f, input logic [AW-1:0] rd, input logic [AW-1:0] r);
    return f[WE_BIT] && rd != '0 && rd == r;
  endfunction
  // Scan oldest to youngest so the youngest matching writer wins the select.
  always_comb begin
    hz_dec = hit(ra_flags, ra_rd, dec_rs1) || hit(ra_flags, ra_rd, dec_rs2);
    hz_ra = 1'b0;
    ld1 = 1'b0;
    ld2 = 1'b0;
    sel1 = '0;
    sel2 = '0;
    for (int s = WB_STAGES - 1; s >= 0; s--) begin
      hz_dec |= hit(wb_flags[s*FLAGS_W +: FLAGS_W], wb_rd[s*AW +: AW], dec_rs1)
             || hit(wb_flags[s*FLAGS_W +: FLAGS_W], wb_rd[s*AW +: AW], dec_rs2);
      if (hit(wb_flags[s*FLAGS_W +: FLAGS_W], wb_rd[s*AW +: AW], ra_rs1)) begin
        hz_ra = 1'b1;
        sel1 = SW'(s + 1);
        ld1 = wb_flags[s*FLAGS_W + LOAD_BIT] && s < WB_STAGES - 1;
      end
      if (hit(wb_flags[s*FLAGS_W +: FLAGS_W], wb_rd[s*AW +: AW], ra_rs2)) begin
        hz_ra = 1'b1;
        sel2 = SW'(s + 1);
        ld2 = wb_flags[s*FLAGS_W + LOAD_BIT] && s < WB_STAGES - 1;
      end
    end
  end
`ifdef PIPELINE_HAZARD_FWD_EN
  assign haz_dec = 1'b0;
  assign haz_ra = ld1 || ld2;
  assign fwd_rs1_sel = rst ? '0 : sel1;
  assign fwd_rs2_sel = rst ? '0 : sel2;
`else
  assign haz_dec = hz_dec;
  assign haz_ra = hz_ra;
  assign fwd_rs1_sel = '0;
  assign fwd_rs2_sel = '0;
`endif
  logic unused_bits;
  assign unused_bits = ^{ra_flags, wb_flags, sel1, sel2, ld1, ld2, hz_dec, hz_ra};
  always_comb begin
    flush = redirect || state == FLUSH;
    fetch_en = !rst && (flush || !(alu_busy || haz_ra || haz_dec));
    dec_latch_en = fetch_en;
    ra_latch_en = !rst && (flush || !(alu_busy || haz_ra));
    alu_latch_en = !rst && (flush || !alu_busy);
    dec_squash = rst || flush;
    ra_squash = rst || flush || (!alu_busy && (haz_ra || haz_dec));
    jmpctrl_en = ra_flags[JALR_BIT] || ra_flags[BRANCH_BIT];
  end
  // The redirect cycle is the first squash cycle, so FLUSH covers the remaining FLUSH_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      flush_cnt <= '0;
      stall_count <= '0;
      run_len <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (redirect) begin
        state <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
        flush_cnt <= FCW'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH && flush_cnt > FCW'(1)) begin
        flush_cnt <= flush_cnt - 1'b1;
      end else begin
        state <= alu_busy ? STALL_MC : (haz_ra || haz_dec) ? STALL_DATA : RUN;
        flush_cnt <= '0;
      end
      stall_count <= stall_count + CNT_W'(!fetch_en && stall_count != '1);
      run_len <= fetch_en ? '0 : run_len + TW'(run_len != TW'(STALL_TIMEOUT));
      stall_timeout <= stall_timeout || run_len == TW'(STALL_TIMEOUT);
    end
  end
endmodule
